// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU control codes and immediate formats shared by the decode stage.
package riscv_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    // instr[30] selects SUB only for register-register ops; SRA/SRAI both use it
    function automatic logic [3:0] alu_from_func3(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'd0:    return (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two async read ports, one sync write port, x0 reads zero, optional WB bypass.
module regfile_2r1w #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int WB_BYPASS = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] mem [NREGS];
    logic            wr;

    assign wr  = we && wa != '0;
    assign rd1 = ra1 == '0 ? '0 : (WB_BYPASS != 0 && wr && wa == ra1) ? wd : mem[ra1];
    assign rd2 = ra2 == '0 ? '0 : (WB_BYPASS != 0 && wr && wa == ra2) ? wd : mem[ra2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[wa] <= wd;
        end
    end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, load-use interlock and ID/EX pipeline register.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int WB_BYPASS  = 1,
    localparam int REG_AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  id_ready,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic                  wb_we,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  id_valid,
    output logic [XLEN-1:0]       id_pc,
    output logic [XLEN-1:0]       id_rs1_data,
    output logic [XLEN-1:0]       id_rs2_data,
    output logic [REG_AW-1:0]     id_rs1,
    output logic [REG_AW-1:0]     id_rs2,
    output logic [REG_AW-1:0]     id_rd,
    output logic [XLEN-1:0]       id_imm,
    output logic [6:0]            id_opcode,
    output logic [2:0]            id_func3,
    output logic [ALU_CTRL_W-1:0] id_alu_ctrl,
    output logic                  id_reg_write,
    output logic                  id_mem_read
);
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm;
    logic [31:0]       imm32;
    logic [3:0]        alu;
    imm_type_e         imm_type;
    logic              known, reg_write, use_rs1, use_rs2, adv, luh;

    assign opcode = if_instr[6:0];
    assign func3  = if_instr[14:12];
    assign rd     = REG_AW'(if_instr[11:7]);
    assign rs1    = REG_AW'(if_instr[19:15]);
    assign rs2    = REG_AW'(if_instr[24:20]);

    regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .WB_BYPASS(WB_BYPASS)) u_rf (
        .clk(clk), .rst(rst),
        .ra1(rs1), .ra2(rs2), .rd1(rs1_data), .rd2(rs2_data),
        .we(wb_we), .wa(wb_rd), .wd(wb_data)
    );

    always_comb begin
        imm_type = IMM_NONE;
        alu      = ALU_ADD;
        known    = 1'b1;
        case (opcode)
            OP_R:             alu = alu_from_func3(func3, if_instr[30], 1'b1);
            OP_I:             begin imm_type = IMM_I; alu = alu_from_func3(func3, if_instr[30], 1'b0); end
            OP_LOAD, OP_JALR: imm_type = IMM_I;
            OP_S:             imm_type = IMM_S;
            OP_BR:            begin imm_type = IMM_B; alu = ALU_SUB; end
            OP_JAL:           imm_type = IMM_J;
            OP_LUI:           begin imm_type = IMM_U; alu = ALU_PASS_B; end
            OP_AUIPC:         imm_type = IMM_U;
            default:          known = 1'b0;
        endcase
    end

    assign imm32 = imm_type == IMM_I ? {{20{if_instr[31]}}, if_instr[31:20]}
                 : imm_type == IMM_S ? {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]}
                 : imm_type == IMM_B ? {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0}
                 : imm_type == IMM_U ? {if_instr[31:12], 12'b0}
                 : imm_type == IMM_J ? {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0}
                 : '0;
    assign imm       = XLEN'($signed(imm32));
    assign reg_write = known && opcode != OP_S && opcode != OP_BR && rd != '0;
    assign use_rs1   = !(opcode inside {OP_JAL, OP_LUI, OP_AUIPC});
    assign use_rs2   = opcode inside {OP_R, OP_S, OP_BR};

    // a load in ID/EX cannot forward to the instruction decoded right behind it
    assign adv      = ex_ready || !id_valid;
    assign luh      = id_valid && id_mem_read && id_rd != '0
                   && ((use_rs1 && rs1 == id_rd) || (use_rs2 && rs2 == id_rd));
    assign id_ready = flush || (adv && !luh);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_rs1_data  <= '0;
            id_rs2_data  <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_rd        <= '0;
            id_imm       <= '0;
            id_opcode    <= '0;
            id_func3     <= '0;
            id_alu_ctrl  <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
        end else if (flush || (adv && luh)) begin
            id_valid <= 1'b0;
        end else if (adv) begin
            id_valid     <= if_valid;
            id_pc        <= if_pc;
            id_rs1_data  <= rs1_data;
            id_rs2_data  <= rs2_data;
            id_rs1       <= rs1;
            id_rs2       <= rs2;
            id_rd        <= rd;
            id_imm       <= imm;
            id_opcode    <= opcode;
            id_func3     <= func3;
            id_alu_ctrl  <= ALU_CTRL_W'(alu);
            id_reg_write <= reg_write;
            id_mem_read  <= opcode == OP_LOAD;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors, hand-written corner sequences and a randomized reference-model run.
module tb_id_stage_pipe;
    import riscv_pkg::*;

    logic        clk, rst, if_valid, flush, ex_ready, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        id_ready, id_valid, id_reg_write, id_mem_read;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_func3;
    logic [3:0]  id_alu_ctrl;
    logic        nb_ready, nb_valid, nb_reg_write, nb_mem_read;
    logic [31:0] nb_pc, nb_rs1_data, nb_rs2_data, nb_imm;
    logic [4:0]  nb_rs1, nb_rs2, nb_rd;
    logic [6:0]  nb_opcode;
    logic [2:0]  nb_func3;
    logic [3:0]  nb_alu_ctrl;

    int passed = 0;
    int total  = 0;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
        .id_opcode(id_opcode), .id_func3(id_func3), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read)
    );

    id_stage_pipe #(.WB_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(nb_ready), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(nb_valid), .id_pc(nb_pc), .id_rs1_data(nb_rs1_data), .id_rs2_data(nb_rs2_data),
        .id_rs1(nb_rs1), .id_rs2(nb_rs2), .id_rd(nb_rd), .id_imm(nb_imm),
        .id_opcode(nb_opcode), .id_func3(nb_func3), .id_alu_ctrl(nb_alu_ctrl),
        .id_reg_write(nb_reg_write), .id_mem_read(nb_mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], OP_S};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], OP_BR};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    // expected ALU operation from the instruction's mnemonic class
    function automatic logic [3:0] exp_alu(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (op == OP_BR) return ALU_SUB;
        if (op == OP_LUI) return ALU_PASS_B;
        if (op != OP_R && op != OP_I) return ALU_ADD;
        case (ins[14:12])
            3'd0:    return (op == OP_R && ins[30]) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ins[30] ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [31:0] ins);
        return (ins[6:0] inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}) && ins[11:7] != 5'd0;
    endfunction

    // random instruction built from a chosen immediate, so the expected immediate is known up front
    task automatic gen_instr(output logic [31:0] ins, output logic [31:0] imm);
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        r   = $urandom;
        rd  = 5'($urandom_range(3));
        rs1 = 5'($urandom_range(3));
        rs2 = 5'($urandom_range(3));
        f3  = 3'($urandom_range(7));
        case ($urandom_range(9))
            0: begin imm = '0; ins = enc_r(($urandom_range(1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd); end
            1: begin imm = {{20{r[11]}}, r[11:0]}; ins = enc_i(imm, rs1, f3, rd, OP_I); end
            2: begin imm = {{20{r[11]}}, r[11:0]}; ins = enc_i(imm, rs1, 3'd2, rd, OP_LOAD); end
            3: begin imm = {{20{r[11]}}, r[11:0]}; ins = enc_s(imm, rs2, rs1); end
            4: begin imm = {{19{r[12]}}, r[12:1], 1'b0}; ins = enc_b(imm, rs2, rs1); end
            5: begin imm = {{11{r[20]}}, r[20:1], 1'b0}; ins = enc_j(imm, rd); end
            6: begin imm = {{20{r[11]}}, r[11:0]}; ins = enc_i(imm, rs1, 3'd0, rd, OP_JALR); end
            7: begin imm = r & 32'hFFFFF000; ins = enc_u(imm, rd, OP_LUI); end
            8: begin imm = r & 32'hFFFFF000; ins = enc_u(imm, rd, OP_AUIPC); end
            default: begin imm = '0; ins = {r[31:7], 7'b0001011}; end
        endcase
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        rw;
        logic        mr;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        rw, mr;
    } idex_t;

    vec_t        vec [12];
    idex_t       m;
    logic [31:0] mregs [32];

    function automatic logic [31:0] mread(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (wb_we && wb_rd == r) return wb_data;
        return mregs[r];
    endfunction

    initial begin
        logic [31:0] p_ins, p_imm, p_pc;
        logic        holding, adv, luh, u1, u2, e_ready;
        logic [4:0]  s1, s2;

        vec[0]  = '{enc_i(32'd5, 5'd0, 3'd0, 5'd1, OP_I),          32'h5,        ALU_ADD,    1'b1, 1'b0};
        vec[1]  = '{enc_i(-32'sd1, 5'd0, 3'd0, 5'd2, OP_I),        32'hFFFFFFFF, ALU_ADD,    1'b1, 1'b0};
        vec[2]  = '{enc_s(-32'sd8, 5'd2, 5'd1),                    32'hFFFFFFF8, ALU_ADD,    1'b0, 1'b0};
        vec[3]  = '{enc_b(-32'sd16, 5'd2, 5'd1),                   32'hFFFFFFF0, ALU_SUB,    1'b0, 1'b0};
        vec[4]  = '{enc_j(32'h800, 5'd1),                          32'h800,      ALU_ADD,    1'b1, 1'b0};
        vec[5]  = '{enc_u(32'hABCDE000, 5'd3, OP_LUI),             32'hABCDE000, ALU_PASS_B, 1'b1, 1'b0};
        vec[6]  = '{enc_u(32'h80000000, 5'd4, OP_AUIPC),           32'h80000000, ALU_ADD,    1'b1, 1'b0};
        vec[7]  = '{enc_i(32'd1, 5'd0, 3'd0, 5'd0, OP_I),          32'h1,        ALU_ADD,    1'b0, 1'b0};
        vec[8]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5),          32'h0,        ALU_SUB,    1'b1, 1'b0};
        vec[9]  = '{enc_i(32'h403, 5'd1, 3'd5, 5'd6, OP_I),        32'h403,      ALU_SRA,    1'b1, 1'b0};
        vec[10] = '{32'hFFFFFFFF,                                  32'h0,        ALU_ADD,    1'b0, 1'b0};
        vec[11] = '{enc_i(32'd4, 5'd1, 3'd2, 5'd5, OP_LOAD),       32'h4,        ALU_ADD,    1'b1, 1'b1};

        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        ex_ready = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset id_valid", id_valid, 0);
        check("reset id_pc", id_pc, 0);
        check("reset id_imm", id_imm, 0);
        check("reset id_reg_write", id_reg_write, 0);
        @(negedge clk);
        check("reset id_ready", id_ready, 1);

        for (int i = 0; i < 12; i++) begin
            if_valid = 1'b1; if_instr = vec[i].ins; if_pc = 32'h100 + 32'(4 * i);
            @(negedge clk);
            check($sformatf("vec%0d ready", i), id_ready, 1);
            tick();
            check($sformatf("vec%0d valid", i), id_valid, 1);
            check($sformatf("vec%0d pc", i), id_pc, 32'h100 + 32'(4 * i));
            check($sformatf("vec%0d imm", i), id_imm, vec[i].imm);
            check($sformatf("vec%0d rd", i), id_rd, vec[i].ins[11:7]);
            check($sformatf("vec%0d alu", i), id_alu_ctrl, vec[i].alu);
            check($sformatf("vec%0d reg_write", i), id_reg_write, vec[i].rw);
            check($sformatf("vec%0d mem_read", i), id_mem_read, vec[i].mr);
        end

        // LW x5 sits in ID/EX; ADD x6,x5,x2 must take exactly one bubble
        if_instr = enc_r(7'h00, 5'd2, 5'd5, 3'd0, 5'd6); if_pc = 32'h200;
        @(negedge clk);
        check("lu ready low", id_ready, 0);
        tick();
        check("lu bubble", id_valid, 0);
        @(negedge clk);
        check("lu ready after bubble", id_ready, 1);
        tick();
        check("lu add valid", id_valid, 1);
        check("lu add rd", id_rd, 6);
        check("lu add pc", id_pc, 32'h200);
        if_instr = enc_i(32'd0, 5'd1, 3'd2, 5'd5, OP_LOAD); if_pc = 32'h204;
        tick();
        check("lu2 load", id_mem_read, 1);
        if_instr = enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd6); if_pc = 32'h208;
        @(negedge clk);
        check("no-lu ready", id_ready, 1);
        tick();
        check("no-lu valid", id_valid, 1);
        check("no-lu pc", id_pc, 32'h208);

        // same-cycle WB bypass versus no-bypass build
        if_instr = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4); if_pc = 32'h20C;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        check("byp rs1", id_rs1_data, 32'hDEADBEEF);
        check("byp rs2", id_rs2_data, 32'hDEADBEEF);
        check("nobyp rs1", nb_rs1_data, 0);
        wb_we = 1'b0;
        if_instr = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4);
        tick();
        check("nobyp rs1 later", nb_rs1_data, 32'hDEADBEEF);
        check("byp x0 rs2", id_rs2_data, 0);

        // x0 write is discarded
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        if_instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
        tick();
        check("x0 bypass read", id_rs1_data, 0);
        wb_we = 1'b0;
        if_instr = enc_i(32'd1, 5'd0, 3'd0, 5'd0, OP_I);
        tick();
        check("x0 read", id_rs1_data, 0);
        check("x0 reg_write", id_reg_write, 0);

        // backpressure holds ID/EX for three cycles
        if_instr = enc_i(32'd7, 5'd0, 3'd0, 5'd8, OP_I); if_pc = 32'h300;
        tick();
        ex_ready = 1'b0;
        if_instr = enc_i(32'd9, 5'd0, 3'd0, 5'd9, OP_I); if_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall ready", id_ready, 0);
            tick();
            check("stall valid", id_valid, 1);
            check("stall rd", id_rd, 8);
            check("stall imm", id_imm, 7);
            check("stall pc", id_pc, 32'h300);
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("release ready", id_ready, 1);
        tick();
        check("release rd", id_rd, 9);
        check("release imm", id_imm, 9);

        // flush beats a pending load-use and drops the incoming instruction
        if_instr = enc_i(32'd0, 5'd1, 3'd2, 5'd5, OP_LOAD); if_pc = 32'h400;
        tick();
        if_instr = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6); flush = 1'b1;
        @(negedge clk);
        check("flush ready", id_ready, 1);
        tick();
        check("flush valid", id_valid, 0);
        flush = 1'b0; if_valid = 1'b0;
        tick();
        check("flush dropped", id_valid, 0);

        // reset in the middle of a stall clears pipeline and register file
        if_valid = 1'b1; if_instr = enc_i(32'd3, 5'd0, 3'd0, 5'd12, OP_I); if_pc = 32'h500;
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h55;
        tick();
        wb_we = 1'b0; ex_ready = 1'b0;
        if_instr = enc_i(32'd4, 5'd0, 3'd0, 5'd13, OP_I);
        tick();
        check("pre-rst valid", id_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst valid", id_valid, 0);
        check("rst pc", id_pc, 0);
        check("rst rd", id_rd, 0);
        ex_ready = 1'b1; if_instr = enc_r(7'h00, 5'd3, 5'd10, 3'd0, 5'd11); if_pc = 32'h600;
        tick();
        check("post-rst valid", id_valid, 1);
        check("post-rst x10", id_rs1_data, 0);
        check("post-rst x3", id_rs2_data, 0);

        // randomized run against the reference model
        if_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        m = '{default: '0};
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        holding = 1'b0; p_ins = '0; p_imm = '0; p_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!holding) begin
                gen_instr(p_ins, p_imm);
                p_pc = $urandom & 32'hFFFFFFFC;
                holding = 1'b1;
            end
            if_valid = $urandom_range(3) != 0; if_instr = p_ins; if_pc = p_pc;
            ex_ready = $urandom_range(3) != 0;
            flush    = $urandom_range(15) == 0;
            wb_we    = $urandom_range(1) != 0;
            wb_rd    = 5'($urandom_range(3));
            wb_data  = $urandom;
            s1  = p_ins[19:15];
            s2  = p_ins[24:20];
            u1  = !(p_ins[6:0] inside {OP_JAL, OP_LUI, OP_AUIPC});
            u2  = p_ins[6:0] inside {OP_R, OP_S, OP_BR};
            adv = ex_ready || !m.v;
            luh = m.v && m.mr && m.rd != 0 && ((u1 && s1 == m.rd) || (u2 && s2 == m.rd));
            e_ready = flush || (adv && !luh);
            @(negedge clk);
            check("rand ready", id_ready, e_ready);
            if (flush || (adv && luh)) m.v = 1'b0;
            else if (adv) m = '{if_valid, p_pc, mread(s1), mread(s2), p_imm, s1, s2, p_ins[11:7],
                                p_ins[6:0], p_ins[14:12], exp_alu(p_ins), writes_rd(p_ins), p_ins[6:0] == OP_LOAD};
            if (wb_we && wb_rd != 0) mregs[wb_rd] = wb_data;
            tick();
            check("rand valid", id_valid, m.v);
            if (m.v) begin
                check("rand pc", id_pc, m.pc);
                check("rand rs1_data", id_rs1_data, m.d1);
                check("rand rs2_data", id_rs2_data, m.d2);
                check("rand imm", id_imm, m.imm);
                check("rand regs", {id_rs1, id_rs2, id_rd}, {m.rs1, m.rs2, m.rd});
                check("rand op/f3", {id_opcode, id_func3}, {m.op, m.f3});
                check("rand alu", id_alu_ctrl, m.alu);
                check("rand ctl", {id_reg_write, id_mem_read}, {m.rw, m.mr});
            end
            if (if_valid && e_ready) holding = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
